// File: rtl/pcie_ce_rx_demux.sv
// Copy-engine RX demux: routes whole AXI-S packets from the PCIe SS RX stream
// to one of NUM_CH channels by PF/VF/vf_active, dropping and counting unmatched packets.
module pcie_ce_rx_demux #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned USER_W       = 10,
    parameter logic [23:0] CH_PF_ID     = {8{3'd4}},
    parameter logic [87:0] CH_VF_ID     = {8{11'd0}},
    parameter logic [7:0]  CH_VF_ACTIVE = 8'h00,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         in_tvalid,
    output logic                         in_tready,
    input  logic [DATA_W-1:0]            in_tdata,
    input  logic [DATA_W/8-1:0]          in_tkeep,
    input  logic                         in_tlast,
    input  logic [USER_W-1:0]            in_tuser,
    output logic [NUM_CH-1:0]            out_tvalid,
    input  logic [NUM_CH-1:0]            out_tready,
    output logic [NUM_CH*DATA_W-1:0]     out_tdata,
    output logic [NUM_CH*DATA_W/8-1:0]   out_tkeep,
    output logic [NUM_CH-1:0]            out_tlast,
    output logic [NUM_CH*USER_W-1:0]     out_tuser,
    output logic [NUM_CH*CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic                         busy
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state;
    logic [CH_W-1:0] cur_ch;

    logic [2:0]      hdr_pf;
    logic [10:0]     hdr_vf;
    logic            hdr_vf_active;
    logic [NUM_CH-1:0] match;
    logic            hit;
    logic [CH_W-1:0] target;

    logic [CH_W-1:0] sel_ch;
    logic            route_fwd;
    logic            accept;
    logic            drop_evt;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;

    assign hdr_pf        = in_tdata[162:160];
    assign hdr_vf        = in_tdata[173:163];
    assign hdr_vf_active = in_tdata[174];

    // Lowest matching channel wins; the descending scan leaves the smallest index last.
    always_comb begin
        match  = '0;
        target = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            match[i] = ch_en[i]
                    && (hdr_pf == CH_PF_ID[3*i +: 3])
                    && (hdr_vf == CH_VF_ID[11*i +: 11])
                    && (hdr_vf_active == CH_VF_ACTIVE[i]);
        end
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (match[i-1]) begin
                target = CH_W'(i - 1);
            end
        end
        hit = |match;
    end

    always_comb begin
        sel_ch    = cur_ch;
        route_fwd = 1'b0;
        in_tready = 1'b0;
        case (state)
            IDLE: begin
                sel_ch    = target;
                route_fwd = hit;
                in_tready = hit ? !full[target] : 1'b1;
            end
            FWD: begin
                route_fwd = 1'b1;
                in_tready = !full[cur_ch];
            end
            DROP: begin
                in_tready = 1'b1;
            end
            default: begin
                in_tready = 1'b0;
            end
        endcase
        if (rst) begin
            in_tready = 1'b0;
        end
    end

    assign accept   = in_tvalid && in_tready;
    assign drop_evt = accept && in_tlast && !route_fwd;

    always_comb begin
        push = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            push[i] = accept && route_fwd && (sel_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur_ch <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_tlast) begin
                        state  <= hit ? FWD : DROP;
                        cur_ch <= target;
                    end
                end
                FWD, DROP: begin
                    if (in_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0] head_data, skid_data;
        logic [KEEP_W-1:0] head_keep, skid_keep;
        logic              head_last, skid_last;
        logic [USER_W-1:0] head_user, skid_user;
        logic              vld;
        logic              fl;
        logic              pop;
        logic [CNT_W-1:0]  cnt;

        assign pop = vld && out_tready[g];

        // Head register drives the port; the skid slot only fills when the head is stalled,
        // so a push never lands while fl is set (in_tready already blocks it).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head_data <= '0;
                head_keep <= '0;
                head_last <= 1'b0;
                head_user <= '0;
                skid_data <= '0;
                skid_keep <= '0;
                skid_last <= 1'b0;
                skid_user <= '0;
                vld       <= 1'b0;
                fl        <= 1'b0;
            end else if (!vld) begin
                if (push[g]) begin
                    head_data <= in_tdata;
                    head_keep <= in_tkeep;
                    head_last <= in_tlast;
                    head_user <= in_tuser;
                    vld       <= 1'b1;
                end
            end else if (!fl) begin
                if (push[g] && pop) begin
                    head_data <= in_tdata;
                    head_keep <= in_tkeep;
                    head_last <= in_tlast;
                    head_user <= in_tuser;
                end else if (push[g]) begin
                    skid_data <= in_tdata;
                    skid_keep <= in_tkeep;
                    skid_last <= in_tlast;
                    skid_user <= in_tuser;
                    fl        <= 1'b1;
                end else if (pop) begin
                    vld <= 1'b0;
                end
            end else if (pop) begin
                head_data <= skid_data;
                head_keep <= skid_keep;
                head_last <= skid_last;
                head_user <= skid_user;
                fl        <= 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (push[g] && in_tlast && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign full[g]                         = fl;
        assign out_tvalid[g]                   = vld;
        assign out_tdata[g*DATA_W +: DATA_W]   = head_data;
        assign out_tkeep[g*KEEP_W +: KEEP_W]   = head_keep;
        assign out_tlast[g]                    = head_last;
        assign out_tuser[g*USER_W +: USER_W]   = head_user;
        assign pkt_cnt[g*CNT_W +: CNT_W]       = cnt;
    end

    assign busy = (state != IDLE) || (|out_tvalid);

endmodule
